// File: rtl/scancode_pkg.sv
// Shared constants and types for the PS/2 set-2 scancode event decoder:
// prefix bytes, FSM state encoding, key table and the queued event format.
package scancode_pkg;

  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam int         MAX_KEYS   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_e;

  // Table position doubles as the glyph index in the character ROM: F Q H X A B C D
  localparam logic [7:0] KEY_TABLE [0:MAX_KEYS-1] = '{
    8'h2B, 8'h15, 8'h33, 8'h22, 8'h1C, 8'h32, 8'h21, 8'h23
  };

  typedef struct packed {
    logic       is_release;
    logic [2:0] index;
  } key_event_t;

endpackage

// File: rtl/scancode_event_decoder_fifo.sv
// Parametrised first-word-fall-through FIFO; the head word is visible on
// pop_data whenever empty is low, and drops on push-while-full are flagged.
module event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full queue still accepts a write when the head leaves on the same edge
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];
  assign overflow = overflow_q;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push && full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/scancode_event_decoder.sv
// PS/2 set-2 prefix tracker that queues make/break glyph events for the VGA
// renderer. Define SCANCODE_KEY_HELD_EN to track held keys and drop typematic repeats.
module scancode_event_decoder
  import scancode_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int ADDR_W       = 7,
  parameter int GLYPH_STRIDE = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              flag,
  input  logic [7:0]        scancode,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [ADDR_W-1:0] start_address_out,
  output logic              key_release,
  output logic              overflow,
  output logic [7:0]        key_held
);

  state_e     state;
  state_e     state_next;
  logic       key_hit;
  logic [2:0] key_idx;
  logic       push_req;
  logic       push_gated;
  key_event_t push_evt;
  key_event_t head_evt;
  logic [$bits(key_event_t)-1:0] head_bits;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  always_comb begin
    key_hit = 1'b0;
    key_idx = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (i < NUM_KEYS && !key_hit && scancode == KEY_TABLE[i]) begin
        key_hit = 1'b1;
        key_idx = 3'(i);
      end
    end
  end

  // Extended-prefixed bytes are swallowed without ever consulting the key table
  always_comb begin
    state_next          = state;
    push_req            = 1'b0;
    push_evt.is_release = 1'b0;
    push_evt.index      = key_idx;
    if (flag) begin
      case (state)
        IDLE: begin
          if (scancode == BRK_PREFIX)      state_next = BRK;
          else if (scancode == EXT_PREFIX) state_next = EXT;
          else                             push_req   = key_hit;
        end
        BRK: begin
          if (scancode == BRK_PREFIX) begin
            state_next = BRK;
          end else if (scancode == EXT_PREFIX) begin
            state_next = EXT_BRK;
          end else begin
            state_next          = IDLE;
            push_req            = key_hit;
            push_evt.is_release = 1'b1;
          end
        end
        EXT:     state_next = (scancode == BRK_PREFIX) ? EXT_BRK : IDLE;
        EXT_BRK: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

`ifdef SCANCODE_KEY_HELD_EN
  logic [7:0] held_q;

  // Held state follows the decision even if the FIFO later drops the event
  assign push_gated = push_req && (push_evt.is_release || !held_q[push_evt.index]);
  assign key_held   = held_q;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n)        held_q <= '0;
    else if (push_req) held_q[push_evt.index] <= !push_evt.is_release;
  end
`else
  assign push_gated = push_req;
  assign key_held   = '0;
`endif

  event_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .vga_clk   (vga_clk),
    .rst_n     (rst_n),
    .push      (push_gated),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );

  assign head_evt   = key_event_t'(head_bits);
  assign char_valid = !fifo_empty;
  assign pop        = char_valid && char_ready;

  assign start_address_out = char_valid ?
                             ADDR_W'(32'(head_evt.index) * 32'(GLYPH_STRIDE)) : '0;
  assign key_release       = char_valid && head_evt.is_release;

endmodule

// File: tb/tb_scancode_event_decoder.sv
// Randomised bench for scancode_event_decoder, checked against a prefix/queue
// model built directly from the PS/2 set-2 make/break rules.
module tb_scancode_event_decoder;

  localparam int TB_NUM_KEYS = 4;
  localparam int TB_ADDR_W   = 7;
  localparam int TB_STRIDE   = 16;
  localparam int TB_DEPTH    = 4;
`ifdef SCANCODE_KEY_HELD_EN
  localparam bit HELD_EN = 1'b1;
`else
  localparam bit HELD_EN = 1'b0;
`endif

  logic                 vga_clk;
  logic                 rst_n;
  logic                 flag;
  logic [7:0]           scancode;
  logic                 char_valid;
  logic                 char_ready;
  logic [TB_ADDR_W-1:0] start_address_out;
  logic                 key_release;
  logic                 overflow;
  logic [7:0]           key_held;

  scancode_event_decoder #(
    .NUM_KEYS     (TB_NUM_KEYS),
    .ADDR_W       (TB_ADDR_W),
    .GLYPH_STRIDE (TB_STRIDE),
    .FIFO_DEPTH   (TB_DEPTH)
  ) dut (
    .vga_clk           (vga_clk),
    .rst_n             (rst_n),
    .flag              (flag),
    .scancode          (scancode),
    .char_valid        (char_valid),
    .char_ready        (char_ready),
    .start_address_out (start_address_out),
    .key_release       (key_release),
    .overflow          (overflow),
    .key_held          (key_held)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int addr;
    bit rel;
  } ev_t;

  logic [7:0] key_codes [8] = '{8'h2B, 8'h15, 8'h33, 8'h22, 8'h1C, 8'h32, 8'h21, 8'h23};

  int       tests_run = 0;
  int       tests_failed = 0;
  ev_t      exp_q[$];
  bit       pre_brk;
  bit       pre_ext;
  bit [7:0] held_m;
  bit       exp_ovf;
  int       ovf_seen;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState();
    checkOutput("char_valid", 32'(char_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      checkOutput("start_address", 32'(start_address_out), 32'(exp_q[0].addr));
      checkOutput("key_release", 32'(key_release), 32'(exp_q[0].rel));
    end
    checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
    checkOutput("key_held", 32'(key_held), 32'(HELD_EN ? held_m : 8'h00));
    if (overflow === 1'b1) ovf_seen++;
  endtask

  // One clock of the reference: prefixes as two flags, events as a bounded queue
  task automatic modelStep(input bit flg, input logic [7:0] b, input bit rdy);
    bit  pop_m;
    bit  push_m;
    ev_t ev;
    int  idx;
    pop_m  = rdy && (exp_q.size() != 0);
    push_m = 1'b0;
    ev.addr = 0;
    ev.rel  = 1'b0;
    if (flg) begin
      if (pre_ext) begin
        if (b == 8'hF0 && !pre_brk) pre_brk = 1'b1;
        else begin
          pre_ext = 1'b0;
          pre_brk = 1'b0;
        end
      end else if (b == 8'hF0) begin
        pre_brk = 1'b1;
      end else if (b == 8'hE0) begin
        pre_ext = 1'b1;
      end else begin
        idx = -1;
        for (int i = 0; i < TB_NUM_KEYS; i++)
          if (idx < 0 && key_codes[i] == b) idx = i;
        if (idx >= 0) begin
          ev.addr = (idx * TB_STRIDE) % (1 << TB_ADDR_W);
          ev.rel  = pre_brk;
          if (!HELD_EN || pre_brk || !held_m[idx]) push_m = 1'b1;
          held_m[idx] = !pre_brk;
        end
        pre_brk = 1'b0;
      end
    end
    exp_ovf = push_m && (exp_q.size() == TB_DEPTH) && !pop_m;
    if (pop_m) void'(exp_q.pop_front());
    if (push_m && exp_q.size() < TB_DEPTH) exp_q.push_back(ev);
  endtask

  task automatic applyStimulus(input bit flg, input logic [7:0] b, input bit rdy);
    @(negedge vga_clk);
    checkState();
    flag       = flg;
    scancode   = b;
    char_ready = rdy;
    modelStep(flg, b, rdy);
  endtask

  // Reset lands just after a clock edge so any pending prefix is mid-flight
  task automatic doReset();
    @(posedge vga_clk);
    #2;
    rst_n      = 1'b0;
    flag       = 1'b0;
    char_ready = 1'b0;
    exp_q.delete();
    pre_brk = 1'b0;
    pre_ext = 1'b0;
    held_m  = '0;
    exp_ovf = 1'b0;
    #1;
    checkOutput("rst_char_valid", 32'(char_valid), 32'h0);
    checkOutput("rst_address", 32'(start_address_out), 32'h0);
    checkOutput("rst_key_release", 32'(key_release), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    checkOutput("rst_key_held", 32'(key_held), 32'h0);
    repeat (2) @(negedge vga_clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < TB_DEPTH + 2; i++) applyStimulus(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int r;
    logic [7:0] b;
    rst_n      = 1'b1;
    flag       = 1'b0;
    scancode   = 8'h00;
    char_ready = 1'b0;
    pre_brk    = 1'b0;
    pre_ext    = 1'b0;
    held_m     = '0;
    exp_ovf    = 1'b0;
    ovf_seen   = 0;
    #3;
    doReset();

    applyStimulus(1'b1, 8'h2B, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);

    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    drain();

    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b0);
    applyStimulus(1'b1, 8'h2B, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h2B, 1'b0);
    applyStimulus(1'b1, 8'h15, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    drain();

    ovf_seen = 0;
    applyStimulus(1'b1, 8'h2B, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h2B, 1'b0);
    applyStimulus(1'b1, 8'h15, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h15, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("overflow_pulses", 32'(ovf_seen), 32'd1);
    drain();

    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    drain();

    applyStimulus(1'b1, 8'h15, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    doReset();
    applyStimulus(1'b1, 8'h2B, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    drain();

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 11));
      if (r < 8)       b = key_codes[r];
      else if (r == 8) b = 8'hF0;
      else if (r == 9) b = 8'hE0;
      else             b = 8'($urandom);
      applyStimulus(($urandom % 4) != 0, b, ($urandom % 3) == 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
